// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
// Shared types and sizing helpers for the sequential signed divider.
//   divider_state_t : FSM states IDLE -> DIVIDE -> FIXUP -> DONE -> IDLE
//   step_count()    : number of restoring-division steps (one per quotient bit)
//   cnt_width()     : width of the step counter, wide enough to hold step_count()
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } divider_state_t;

  // One step per bit of the (2*WIDTH+2)-bit dividend.
  function automatic int unsigned step_count(input int unsigned width);
    return 2 * width + 2;
  endfunction

  // Counter must represent the full step count itself, hence the +3.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(2 * width + 3);
  endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step
// One combinational iteration of unsigned restoring division.
//   rem_in   : current partial remainder (WIDTH+2 bits)
//   next_bit : next dividend bit shifted into the remainder
//   div_mag  : divisor magnitude (WIDTH+1 bits)
//   rem_out  : partial remainder after the conditional subtract
//   q_bit    : quotient bit produced by this step
module divider_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+1:0] rem_in,
  input  logic             next_bit,
  input  logic [WIDTH:0]   div_mag,
  output logic [WIDTH+1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The shifted value is conceptually WIDTH+3 bits wide; its top bit is
  // rem_in's MSB. When that bit is set the value certainly exceeds the
  // divisor, so it forces a subtract and the modulo-2^(WIDTH+2) difference
  // is still the right answer. With a nonzero divisor it is always clear.
  always_comb begin
    shifted = {rem_in[WIDTH:0], next_bit};
    diff    = shifted - {1'b0, div_mag};
    q_bit   = rem_in[WIDTH+1] | (shifted >= {1'b0, div_mag});
    rem_out = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Multi-cycle signed divider using restoring division, one quotient bit per
// cycle, with a start/valid handshake and fixed latency of 2*WIDTH+4 cycles.
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   dividend  : signed (2*WIDTH+2)-bit dividend, sampled when accepted
//   divisor   : signed (WIDTH+1)-bit divisor, sampled when accepted
//   start     : request, honoured only in IDLE
//   busy      : high in every state except IDLE
//   quotient  : signed quotient, truncated toward zero (-1 on divide by zero)
//   remainder : signed remainder, sign of the dividend (0 on divide by zero)
//   div_zero  : result was produced with a zero divisor
//   valid     : one-cycle pulse, results stable while high
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic signed [2*WIDTH+1:0] dividend,
  input  logic signed [WIDTH:0]  divisor,
  input  logic                   start,
  output logic                   busy,
  output logic signed [2*WIDTH+1:0] quotient,
  output logic signed [WIDTH:0]  remainder,
  output logic                   div_zero,
  output logic                   valid
);

  localparam int DW = 2 * WIDTH + 2;
  localparam int VW = WIDTH + 1;
  localparam int RW = WIDTH + 2;
  localparam int CW = int'(cnt_width(WIDTH));
  localparam logic [CW-1:0] STEPS = CW'(step_count(WIDTH));

  divider_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  dvd_q, dvd_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [VW-1:0]  dvs_q, dvs_d;
  logic           q_neg_q, q_neg_d;
  logic           r_neg_q, r_neg_d;
  logic           dz_q, dz_d;
  logic [DW-1:0]  quotient_q, quotient_d;
  logic [VW-1:0]  remainder_q, remainder_d;
  logic           div_zero_q, div_zero_d;
  logic           valid_q, valid_d;

  logic [DW-1:0]  dvd_bits;
  logic [VW-1:0]  dvs_bits;
  logic [DW-1:0]  dvd_abs;
  logic [VW-1:0]  dvs_abs;
  logic [RW-1:0]  step_rem;
  logic           step_q;

  // Magnitudes are taken at the operand width; the most-negative value
  // negates to itself, which read as unsigned is exactly 2^(n-1).
  always_comb begin
    dvd_bits = dividend;
    dvs_bits = divisor;
    dvd_abs  = dvd_bits[DW-1] ? -dvd_bits : dvd_bits;
    dvs_abs  = dvs_bits[VW-1] ? -dvs_bits : dvs_bits;
  end

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in   (rem_q),
    .next_bit (dvd_q[DW-1]),
    .div_mag  (dvs_q),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  // dvd_q doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom, so after all steps it holds
  // the quotient magnitude.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    valid_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dvd_abs;
          dvs_d   = dvs_abs;
          r_neg_d = dvd_bits[DW-1];
          q_neg_d = dvd_bits[DW-1] ^ dvs_bits[VW-1];
          dz_d    = (dvs_bits == '0);
          rem_d   = '0;
          cnt_d   = STEPS;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DW-2:0], step_q};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        // Remainder magnitude is below the divisor magnitude, so its top
        // partial-remainder bit is never needed here.
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = '0;
        end else begin
          quotient_d  = q_neg_q ? -dvd_q : dvd_q;
          remainder_d = r_neg_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];
        end
        div_zero_d = dz_q;
        valid_d    = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      valid_q     <= valid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=10). A behavioural model
// computes each result with plain integer division and tracks the fixed
// handshake timing; a compare process checks every output on every cycle,
// and directed cases pin the model with hand-computed values.
module tb_seq_divider;

  localparam int WIDTH   = 10;
  localparam int DW      = 2 * WIDTH + 2;
  localparam int VW      = WIDTH + 1;
  localparam int LATENCY = 2 * WIDTH + 4;

  logic                 clock;
  logic                 reset_n;
  logic                 start;
  logic                 busy;
  logic                 div_zero;
  logic                 valid;
  logic signed [DW-1:0] dividend;
  logic signed [DW-1:0] quotient;
  logic signed [VW-1:0] divisor;
  logic signed [VW-1:0] remainder;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  seq_divider #(
    .WIDTH (WIDTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .dividend  (dividend),
    .divisor   (divisor),
    .start     (start),
    .busy      (busy),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .valid     (valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference arithmetic: SV integer division truncates toward zero and
  // the remainder takes the dividend's sign; the quotient wraps at DW bits.
  function automatic longint refQuot(input longint a, input longint b);
    longint q;
    logic [DW-1:0] t;
    if (b == 0) return -1;
    q = a / b;
    t = q[DW-1:0];
    return longint'($signed(t));
  endfunction

  function automatic longint refRem(input longint a, input longint b);
    if (b == 0) return 0;
    return a % b;
  endfunction

  // Model: phase counts cycles since acceptance (0 = idle); results become
  // visible, with valid, in the cycle numbered LATENCY.
  int     phase  = 0;
  longint pendQ  = 0;
  longint pendR  = 0;
  bit     pendDz = 1'b0;
  longint expQ   = 0;
  longint expR   = 0;
  bit     expDz  = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 0;
      expQ  <= 0;
      expR  <= 0;
      expDz <= 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        pendQ  <= refQuot(longint'(dividend), longint'(divisor));
        pendR  <= refRem(longint'(dividend), longint'(divisor));
        pendDz <= (divisor == 0);
        phase  <= 1;
      end
    end else if (phase == LATENCY) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
      if (phase == LATENCY - 1) begin
        expQ  <= pendQ;
        expR  <= pendR;
        expDz <= pendDz;
      end
    end
  end

  task automatic cmp(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle: handshake timing and held outputs against the model.
  always @(negedge clock) begin
    if (checkEn) begin
      cmp("busy", longint'(busy), longint'(phase != 0));
      cmp("valid", longint'(valid), longint'(phase == LATENCY));
      cmp("quotient", longint'(quotient), expQ);
      cmp("remainder", longint'(remainder), expR);
      cmp("div_zero", longint'(div_zero), longint'(expDz));
    end
  end

  function automatic longint randDvd();
    logic [DW-1:0] t;
    t = DW'($urandom);
    case ($urandom_range(0, 5))
      0:       return -(longint'(1) << (DW - 1));
      1:       return (longint'(1) << (DW - 1)) - 1;
      default: return longint'($signed(t));
    endcase
  endfunction

  function automatic longint randDvs();
    logic [VW-1:0] t;
    t = VW'($urandom);
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return -(longint'(1) << (VW - 1));
      2:       return -1;
      3:       return longint'($urandom_range(1, 15));
      4:       return -longint'($urandom_range(1, 15));
      default: return longint'($signed(t));
    endcase
  endfunction

  // One-cycle start pulse; operands are scrambled after acceptance so any
  // dependence on them while busy shows up as a wrong result.
  task automatic applyStimulus(input longint a, input longint b);
    @(negedge clock);
    dividend = DW'(a);
    divisor  = VW'(b);
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
  endtask

  // Called in cycle 1 after acceptance; waits for valid within a bound.
  task automatic waitValid(input string name);
    int n;
    n = 1;
    while (!valid && n < 2 * LATENCY) begin
      @(negedge clock);
      n++;
    end
    cmp({name, " latency"}, longint'(n), longint'(LATENCY));
  endtask

  task automatic checkOutput(input string name, input longint q, input longint r, input bit dz);
    cmp({name, " valid"}, longint'(valid), 1);
    cmp({name, " quotient"}, longint'(quotient), q);
    cmp({name, " remainder"}, longint'(remainder), r);
    cmp({name, " div_zero"}, longint'(div_zero), longint'(dz));
  endtask

  task automatic checkIdleZero(input string name);
    cmp({name, " busy"}, longint'(busy), 0);
    cmp({name, " valid"}, longint'(valid), 0);
    cmp({name, " quotient"}, longint'(quotient), 0);
    cmp({name, " remainder"}, longint'(remainder), 0);
    cmp({name, " div_zero"}, longint'(div_zero), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    reset_n  = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1 reset_n = 1'b0;
    #1 checkIdleZero("reset");
    checkEn = 1'b1;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;

    // Directed cases with hand-computed results.
    applyStimulus(100, 7);
    waitValid("100/7");
    checkOutput("100/7", 14, 2, 1'b0);

    applyStimulus(-100, 7);
    waitValid("-100/7");
    checkOutput("-100/7", -14, -2, 1'b0);

    applyStimulus(100, -7);
    waitValid("100/-7");
    checkOutput("100/-7", -14, 2, 1'b0);

    applyStimulus(-100, -7);
    waitValid("-100/-7");
    checkOutput("-100/-7", 14, -2, 1'b0);

    applyStimulus(-2097152, -1);
    waitValid("minneg/-1");
    checkOutput("minneg/-1", -2097152, 0, 1'b0);

    applyStimulus(2097151, -1024);
    waitValid("maxpos/-1024");
    checkOutput("maxpos/-1024", -2047, 1023, 1'b0);

    applyStimulus(5, 0);
    waitValid("5/0");
    checkOutput("5/0", -1, 0, 1'b1);

    applyStimulus(9, 3);
    waitValid("9/3");
    checkOutput("9/3", 3, 0, 1'b0);

    // start held high with operands changing every cycle: results every
    // LATENCY+1 cycles, so four pulses land in a 100-cycle window.
    @(negedge clock);
    dividend = DW'(randDvd());
    divisor  = VW'(randDvs());
    start    = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (valid) pulses++;
      dividend = DW'(randDvd());
      divisor  = VW'(randDvs());
    end
    start = 1'b0;
    cmp("held-start pulses", longint'(pulses), 4);
    repeat (LATENCY + 2) @(negedge clock);

    // Reset 10 cycles into an operation aborts it with outputs cleared.
    applyStimulus(1234, 5);
    repeat (9) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 checkIdleZero("mid-op reset");
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (LATENCY + 2) @(negedge clock);

    applyStimulus(1000, 10);
    waitValid("1000/10");
    checkOutput("1000/10", 100, 0, 1'b0);

    // Randomized operations with random idle gaps; the compare process
    // checks every result against the model.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(randDvd(), randDvs());
      waitValid("random");
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (4) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
